// File: rtl/fib_seq_checker.sv
// Sequential Fibonacci-membership checker for N-bit operands.
// Iterative a/b generator with valid/ready in and out, plus a saturating hit counter.
module fib_seq_checker #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_value,
  output logic             out_is_fib,
  output logic             busy,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] hit_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [N-1:0] v;
  logic [N:0]   a;
  logic [N:0]   b;
  logic         reached;
  logic         take;
  logic         give;

  assign reached   = (b >= {1'b0, v});
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign take      = in_valid && in_ready;
  assign give      = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; DONE only leaves on a real handshake.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (take) state_nx = CALC;
      CALC:    if (reached) state_nx = DONE;
      DONE:    if (give) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Generator datapath: operand latch and the a/b term pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      a <= '0;
      b <= {{N{1'b0}}, 1'b1};
    end else if (take) begin
      v <= in_value;
      a <= '0;
      b <= {{N{1'b0}}, 1'b1};
    end else if (state == CALC && !reached) begin
      a <= b;
      b <= a + b;
    end
  end

  // Result registers; out_valid rises the cycle after DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_value  <= '0;
      out_is_fib <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= (state == DONE) && !give;
      if (state == CALC && reached) begin
        out_value  <= v;
        out_is_fib <= (a == {1'b0, v}) || (b == {1'b0, v});
      end
    end
  end

  // Saturating hit counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (cnt_clear) begin
      hit_cnt <= '0;
    end else if (give && out_is_fib && (hit_cnt != '1)) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end

endmodule

// File: doc/fib_seq_checker.md
Name: fib_seq_checker

Overview:
- Sequential Fibonacci-membership checker for N-bit values, generalising the team's fixed 4-bit combinational Fibonacci detector to any width.
- An FSM drives an iterative Fibonacci generator datapath (registers a, b and one adder) and compares the operand against the generated terms.
- Sits between an upstream value stream and a downstream result consumer. Both sides use valid/ready handshakes.
- Keeps a saturating count of Fibonacci hits.

Parameters:
- N, 8, operand width in bits (N >= 2).
- CNT_W, 16, width of the hit counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  upstream offers in_value.
- in_ready  output  1  block can accept an operand.
- in_value  input  N  operand to classify.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_value  output  N  operand the result belongs to.
- out_is_fib  output  1  1 when out_value is a Fibonacci number (0,1,2,3,5,8,...).
- busy  output  1  FSM is not in IDLE.
- cnt_clear  input  1  synchronous clear of hit_cnt.
- hit_cnt  output  CNT_W  number of accepted results with out_is_fib=1; saturates.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0; out_value=0; out_is_fib=0; busy=0; hit_cnt=0.
  - Internal registers v=0, a=0, b=1.
  - Asserting reset mid-operation aborts the operand with no result; the block restarts in IDLE after rst_n rises.
- Registers:
  - v: N bits, latched operand.
  - a: N+1 bits.
  - b: N+1 bits. Sum a+b is computed N+1 bits wide and never wraps, because iteration stops once b >= v and v <= 2^N-1.
- States:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On in_valid&in_ready: v<=in_value, a<=0, b<=1, go CALC.
  - CALC:
    - in_ready=0.
    - Each cycle test b >= v (zero-extended). If true: out_is_fib<=(a==v)||(b==v), out_value<=v, go DONE.
    - Otherwise a<=b, b<=a+b, stay in CALC.
  - DONE:
    - out_valid=1; out_value and out_is_fib are held stable while out_ready=0.
    - On out_ready: go IDLE, and if out_is_fib=1 increment hit_cnt.
    - in_ready=0 in DONE, so there is no accept in the same cycle as result acceptance.
- Latency:
  - Accept at edge t.
  - CALC occupies k cycles, where k = 1 + the number of iterations needed until b >= v.
  - out_valid rises at edge t+k+1.
  - Examples: v=0 or v=1 give k=1; v=13 gives k=7; for N=8, v=255 gives k=14 (worst case).
- busy = (state != IDLE).
- hit_cnt:
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clear has priority over an increment in the same cycle; the result is 0.
  - cnt_clear does not disturb the FSM.
- in_value is sampled only on the accept edge. Changes while busy are ignored.
- All outputs are registered or derived only from state; there is no combinational path from in_valid or out_ready to any output.

Test Plan:
- Reset mid-CALC: drive rst_n low while checking v=13 -> outputs immediately return to their reset values; no out_valid ever appears for 13; the next operand is processed normally.
- N=4, exhaustive sweep of 0..15 with out_ready=1 -> out_is_fib=1 exactly for {0,1,2,3,5,8,13}; hit_cnt=7 at the end.
- N=8, latency: v=0 -> out_valid 2 cycles after accept; v=13 -> 8 cycles, is_fib=1; v=4 -> 6 cycles, is_fib=0; v=255 -> 15 cycles, is_fib=0; v=233 -> 14 cycles, is_fib=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with v=21 -> out_valid, out_value=21 and out_is_fib=1 stay stable; in_ready=0 throughout; hit_cnt increments once only, on the cycle out_ready=1.
- in_value changes during CALC: accept v=34, then drive in_value=35 while busy -> result out_value=34, is_fib=1.
- Counter: CNT_W=2, feed five Fibonacci values -> hit_cnt saturates at 3. Then assert cnt_clear in the same cycle as a Fibonacci result acceptance -> hit_cnt=0.
